// File: rtl/add_sub_4b.sv
// add_sub_4b
//   Registered two's-complement adder/subtractor for the datapath ALU slice.
//   The operation is a ripple-carry chain of full-adder cells. The sum and
//   carry are registered, so each result appears one clock after its operands.
//   A new pair of operands is accepted on every edge.
//
// Parameters
//   WIDTH  operand/result width in bits (production value 4, any WIDTH >= 1)
//
// Ports
//   clk    clock; all state updates on the rising edge
//   rst_n  asynchronous active-low reset; clears every output register
//   A      operand A (minuend when subtracting)
//   Y      operand Y (subtrahend when subtracting)
//   Cin    0 = add (A + Y), 1 = subtract (A + ~Y + 1); also the LSB carry-in
//   S      registered sum/difference, modulo 2^WIDTH
//   Cout   registered carry out of the MSB cell (subtract: 1 = no borrow)
//   Ovf    registered signed overflow       (only with ADD_SUB_4B_FLAGS_EN)
//   Zero   registered (S == 0) flag         (only with ADD_SUB_4B_FLAGS_EN)
//
// Configuration
//   Define ADD_SUB_4B_FLAGS_EN to add the Ovf and Zero flag outputs.
//   S and Cout behave identically with or without the flags.
module add_sub_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Y,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout
`ifdef ADD_SUB_4B_FLAGS_EN
  ,
  output logic             Ovf,
  output logic             Zero
`endif
);

  // Combinational datapath.
  logic [WIDTH-1:0] yx;     // Y, inverted when subtracting
  logic [WIDTH:0]   carry;  // carry[0] is the LSB carry-in
  logic [WIDTH-1:0] sum;

  // Subtraction is A + ~Y + 1. Cin both inverts Y and supplies the +1.
  assign carry[0] = Cin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign yx[gi]      = Y[gi] ^ Cin;
      assign sum[gi]     = A[gi] ^ yx[gi] ^ carry[gi];
      assign carry[gi+1] = (A[gi] & yx[gi]) | (carry[gi] & (A[gi] ^ yx[gi]));
    end
  endgenerate

  // Output registers.
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg    <= '0;
      cout_reg <= 1'b0;
    end else begin
      s_reg    <= sum;
      cout_reg <= carry[WIDTH];
    end
  end

  assign S    = s_reg;
  assign Cout = cout_reg;

`ifdef ADD_SUB_4B_FLAGS_EN
  logic ovf_reg;
  logic zero_reg;

  // Signed overflow: the carry into the sign bit differs from the carry out
  // of it. This works for subtract as well, because subtract is an add of ~Y + 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
    end else begin
      ovf_reg  <= carry[WIDTH] ^ carry[WIDTH-1];
      zero_reg <= (sum == '0);
    end
  end

  assign Ovf  = ovf_reg;
  assign Zero = zero_reg;
`endif

endmodule

// File: tb/tb_add_sub_4b.sv
// tb_add_sub_4b
//   Self-checking bench for add_sub_4b at WIDTH = 4. Expected results come
//   from integer arithmetic on the operand values. Directed cases run first,
//   then a block of back-to-back random operations, and then a reset
//   asserted in the middle of the stream.
module tb_add_sub_4b;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] y_in = '0;
  logic         cin_in = 1'b0;
  logic [W-1:0] s_out;
  logic         cout_out;
`ifdef ADD_SUB_4B_FLAGS_EN
  logic         ovf_out;
  logic         zero_out;
`endif

  int total = 0;
  int bad   = 0;

  add_sub_4b #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (a_in),
    .Y    (y_in),
    .Cin  (cin_in),
    .S    (s_out),
    .Cout (cout_out)
`ifdef ADD_SUB_4B_FLAGS_EN
    ,
    .Ovf  (ovf_out),
    .Zero (zero_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: integer arithmetic on the operands.
  function automatic void model(input int a, input int y, input bit cin,
                                output int s, output bit cout,
                                output bit ovf, output bit zero);
    int r, sa, sy, sr;
    if (!cin) begin
      r    = a + y;
      s    = r % M;
      cout = (r >= M);
    end else begin
      r    = a - y;
      s    = (r < 0) ? r + M : r;
      cout = (a >= y);
    end
    sa   = (a >= M/2) ? a - M : a;
    sy   = (y >= M/2) ? y - M : y;
    sr   = cin ? sa - sy : sa + sy;
    ovf  = (sr > M/2 - 1) || (sr < -(M/2));
    zero = (s == 0);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Drive one operation just after an edge. On the next edge, check the
  // registered result. Calls made back to back give one operation per cycle.
  task automatic step(input int a, input int y, input bit cin, input string tag);
    int es;
    bit ec, eo, ez;
    a_in   = a[W-1:0];
    y_in   = y[W-1:0];
    cin_in = cin;
    model(a, y, cin, es, ec, eo, ez);
    @(posedge clk);
    #1;
    $display("op %s: A=%0h Y=%0h Cin=%0b -> S=%0h Cout=%0b (exp S=%0h Cout=%0b)",
             tag, a, y, cin, s_out, cout_out, es, ec);
    check({tag, ".S"}, int'(s_out), es);
    check({tag, ".Cout"}, int'(cout_out), int'(ec));
`ifdef ADD_SUB_4B_FLAGS_EN
    check({tag, ".Ovf"}, int'(ovf_out), int'(eo));
    check({tag, ".Zero"}, int'(zero_out), int'(ez));
`endif
  endtask

  initial begin
    int ra, ry;
    bit rc;

    // Asynchronous reset: the outputs clear before any clock edge.
    a_in = 4'h9; y_in = 4'h3; cin_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset.S", int'(s_out), 0);
    check("reset.Cout", int'(cout_out), 0);
`ifdef ADD_SUB_4B_FLAGS_EN
    check("reset.Ovf", int'(ovf_out), 0);
    check("reset.Zero", int'(zero_out), 0);
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed add cases.
    step(4'h1, 4'h0, 1'b0, "add1");
    step(4'h0, 4'h1, 1'b0, "add2");
    step(4'h6, 4'h1, 1'b0, "add3");
    step(4'hF, 4'h1, 1'b0, "addwrap");
    // Directed subtract cases, without and with a borrow.
    step(4'hC, 4'hA, 1'b1, "sub1");
    step(4'hF, 4'h7, 1'b1, "sub2");
    step(4'hB, 4'hF, 1'b1, "subborrow1");
    step(4'h0, 4'h1, 1'b1, "subborrow2");
    // Signed-overflow and zero-result cases.
    step(4'h7, 4'h1, 1'b0, "flagovf");
    step(4'h5, 4'h5, 1'b1, "flagzero");

    // Back-to-back random operations, one per cycle.
    for (int i = 0; i < 40; i++) begin
      ra = int'($urandom_range(M - 1, 0));
      ry = int'($urandom_range(M - 1, 0));
      rc = 1'($urandom_range(1, 0));
      step(ra, ry, rc, $sformatf("rand%0d", i));
    end

    // Reset in the middle of the stream. Drive an operand pair first, then
    // assert rst_n between edges. The outputs must clear at once.
    step(4'h9, 4'h4, 1'b0, "prereset");
    a_in = 4'hE; y_in = 4'h1; cin_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset.S", int'(s_out), 0);
    check("midreset.Cout", int'(cout_out), 0);
    @(posedge clk);
    #1;
    check("heldreset.S", int'(s_out), 0);
    check("heldreset.Cout", int'(cout_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'hA, 4'h3, 1'b1, "postreset");
    step(4'h8, 4'h8, 1'b0, "postreset2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
